// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Synchronises rx, qualifies the start bit at
// mid-bit, then samples each data bit and the stop bit at its centre.
module uart_rx #(
    parameter int BAUD = 115200,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB   = F / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] CNT_BIT = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic             rx_p0, rx_p1, rx_s;
    logic             armed;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             valid_nxt, ferr_nxt;

    assign rx_s = rx_p1;
    assign busy = (state != IDLE);

    // stage p0/p1: two-flop synchroniser, then control state update
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0     <= 1'b1;
            rx_p1     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            armed     <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            data      <= 8'h00;
        end else begin
            rx_p0     <= rx;
            rx_p1     <= rx_p0;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
            if (valid_nxt)
                data <= shreg;
            // a bad stop bit disarms until the line has been seen high again
            if (ferr_nxt)
                armed <= 1'b0;
            else if (rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (armed && !rx_s)
                    state_nxt = START;
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s)
                        valid_nxt = 1'b1;
                    else
                        ferr_nxt = 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven from tasks, expected bytes are
// queued when a frame starts and popped when valid pulses.
module tb_uart_rx;

    localparam int BAUD = 115200;
    localparam int F    = 50000000;
    localparam int CPB  = F / BAUD;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    bit         lat_en = 1'b0;
    logic [7:0] exp_q[$];
    int         valid_cyc[$];

    uart_rx #(.BAUD(BAUD), .F(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard side: compare every output pulse as it appears
    always @(negedge clk) begin
        if (!rst) begin
            if (valid || frame_err)
                check("valid_ferr_excl", {31'd0, valid & frame_err}, 32'd0);
            if (frame_err)
                n_ferr++;
            if (valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    logic [7:0] e;
                    int lat;
                    e = exp_q.pop_front();
                    check("rx_data", {24'd0, data}, {24'd0, e});
                    if (lat_en) begin
                        lat = cyc - t_start;
                        check("latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
                    end
                end else begin
                    check("unexpected_valid", {31'd0, valid}, 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bitp, input logic stop_b);
        t_start = cyc;
        drive(1'b0, bitp);
        for (int i = 0; i < 8; i++)
            drive(b[i], bitp);
        drive(stop_b, bitp);
    endtask

    initial begin
        int v0, f0;
        logic [7:0] b9b;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 20);

        // loopback pair
        lat_en = 1'b1;
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(8'hD3);
        send_byte(8'hD3, CPB, 1'b1);
        drive(1'b1, 5);
        check("loop_busy_gap", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h2C);
        send_byte(8'h2C, CPB, 1'b1);
        drive(1'b1, 20);
        check("loop_nvalid", n_valid - v0, 2);
        check("loop_nferr", n_ferr - f0, 0);
        check("loop_data", {24'd0, data}, 32'h2C);

        // short low glitch
        v0 = n_valid; f0 = n_ferr;
        drive(1'b0, 100);
        drive(1'b1, HALF + 3);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_nvalid", n_valid - v0, 0);
        check("glitch_nferr", n_ferr - f0, 0);

        // framing error followed by line held low
        exp_q.push_back(8'hD3);
        send_byte(8'hD3, CPB, 1'b1);
        drive(1'b1, 20);
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h2C, CPB, 1'b0);
        drive(1'b0, 2000);
        check("ferr_count", n_ferr - f0, 1);
        check("ferr_nvalid", n_valid - v0, 0);
        check("ferr_data_kept", {24'd0, data}, 32'hD3);
        check("ferr_no_restart", {31'd0, busy}, 32'd0);
        drive(1'b1, CPB);
        exp_q.push_back(8'h2C);
        send_byte(8'h2C, CPB, 1'b1);
        drive(1'b1, 20);
        check("after_ferr_nvalid", n_valid - v0, 1);
        check("after_ferr_data", {24'd0, data}, 32'h2C);

        // reset during data bit 4 of 0x9B
        v0 = n_valid; f0 = n_ferr;
        b9b = 8'h9B;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++)
            drive(b9b[i], CPB);
        drive(b9b[4], HALF);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2 * CPB);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_data", {24'd0, data}, 32'h00);
        check("rstmid_nvalid", n_valid - v0, 0);
        check("rstmid_nferr", n_ferr - f0, 0);
        exp_q.push_back(8'hD9);
        send_byte(8'hD9, CPB, 1'b1);
        drive(1'b1, 20);
        check("rstmid_next_data", {24'd0, data}, 32'hD9);

        // back-to-back, single stop bit between frames
        v0 = n_valid;
        valid_cyc.delete();
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, CPB, 1'b1);
        exp_q.push_back(8'h00);
        send_byte(8'h00, CPB, 1'b1);
        drive(1'b1, 20);
        check("b2b_nvalid", n_valid - v0, 2);
        if (valid_cyc.size() == 2) begin
            int gap;
            gap = valid_cyc[1] - valid_cyc[0];
            check("b2b_spacing", (gap >= 10 * CPB - 2 && gap <= 10 * CPB + 2) ? 10 * CPB : gap, 10 * CPB);
        end else begin
            check("b2b_pulses", valid_cyc.size(), 2);
        end

        // transmitter 2% slow
        lat_en = 1'b0;
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(8'hEF);
        send_byte(8'hEF, 443, 1'b1);
        drive(1'b1, 20);
        check("skew_nvalid", n_valid - v0, 1);
        check("skew_nferr", n_ferr - f0, 0);
        check("skew_data", {24'd0, data}, 32'hEF);

        check("queue_drained", exp_q.size(), 0);
        check("total_ferr", n_ferr, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
